// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation engine: FSM state encoding.
package modexp_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SQR  = 3'd2,
    MUL  = 3'd3,
    FIN  = 3'd4
  } modexp_state_t;

endpackage

// File: rtl/modexp_engine_modmul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, one bit of a per cycle, MSB first.
module modmul_serial
  import modexp_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] p_base;
  logic             a_bit;
  logic [WIDTH+1:0] acc0;
  logic [WIDTH+1:0] acc1;
  logic [WIDTH+1:0] n_ext;

  // One shift-add-reduce step; p carries the fully reduced step value so the
  // caller can capture the product on the same edge that ready is seen.
  always_comb begin
    n_ext  = {2'b00, n};
    p_base = (cnt == '0) ? '0 : p_reg;
    a_bit  = a[LAST - cnt];
    acc0   = {1'b0, p_base, 1'b0} + (a_bit ? {2'b00, b} : '0);
    acc1   = (acc0 >= n_ext) ? acc0 - n_ext : acc0;
    p      = (acc1 >= n_ext) ? WIDTH'(acc1 - n_ext) : acc1[WIDTH-1:0];
    ready  = go && (cnt == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      p_reg <= '0;
    end else if (go) begin
      p_reg <= p;
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/modexp_engine.sv
// Constant-time left-to-right square-and-multiply modular exponentiation engine.
module modexp_engine
  import modexp_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] exponent,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);

  modexp_state_t    state, next_state;
  logic [WIDTH-1:0] base_r, mod_r, exp_r, r_reg;
  logic [IDX_W-1:0] bit_idx;
  logic             operands_bad;
  logic             mul_go, mul_ready;
  logic [WIDTH-1:0] mul_b, mul_p;

  assign operands_bad = (mod_r == '0) || (base_r >= mod_r);

  modmul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .go   (mul_go),
    .a    (r_reg),
    .b    (mul_b),
    .n    (mod_r),
    .p    (mul_p),
    .ready(mul_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The multiplier runs for every bit in both phases; only the write-back of
  // the MUL product depends on the exponent bit, keeping latency fixed.
  always_comb begin
    next_state = state;
    mul_go     = 1'b0;
    mul_b      = r_reg;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: next_state = operands_bad ? FIN : SQR;
      SQR: begin
        mul_go = 1'b1;
        if (mul_ready) next_state = MUL;
      end
      MUL: begin
        mul_go = 1'b1;
        mul_b  = base_r;
        if (mul_ready) next_state = (bit_idx == '0) ? FIN : SQR;
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r  <= '0;
      mod_r   <= '0;
      exp_r   <= '0;
      r_reg   <= '0;
      bit_idx <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            mod_r  <= modulus;
            exp_r  <= exponent;
            error  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        LOAD: begin
          if (operands_bad) begin
            error <= 1'b1;
          end else begin
            r_reg   <= {{(WIDTH-1){1'b0}}, (mod_r != WIDTH'(1))};
            bit_idx <= TOP_IDX;
          end
        end
        SQR: begin
          if (mul_ready) r_reg <= mul_p;
        end
        MUL: begin
          if (mul_ready) begin
            if (exp_r[bit_idx]) r_reg <= mul_p;
            if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
          end
        end
        FIN: begin
          result <= error ? '0 : r_reg;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_engine.sv
// Directed self-checking bench for modexp_engine at WIDTH=6 and WIDTH=16.
module tb_modexp_engine;

  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start6 = 1'b0;
  logic [5:0] base6 = '0, mod6 = '0, exp6 = '0;
  logic [5:0] res6;
  logic       busy6, done6, err6;

  logic        start16 = 1'b0;
  logic [15:0] base16 = '0, mod16 = '0, exp16 = '0;
  logic [15:0] res16;
  logic        busy16, done16, err16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  modexp_engine #(.WIDTH(6)) dut6 (
    .clk(clk), .rst(rst), .start(start6), .base(base6), .modulus(mod6),
    .exponent(exp6), .result(res6), .busy(busy6), .done(done6), .error(err6)
  );

  modexp_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .base(base16), .modulus(mod16),
    .exponent(exp16), .result(res16), .busy(busy16), .done(done16), .error(err16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one operation; pulse_at >= 0 injects a second start (with other operands) mid-run.
  task automatic applyStimulus(input int sel, input logic [15:0] b, input logic [15:0] n,
                               input logic [15:0] e, input int pulse_at,
                               output logic [15:0] res, output logic er, output int lat);
    logic seen;
    @(negedge clk);
    if (sel == 16) begin
      base16 = b; mod16 = n; exp16 = e; start16 = 1'b1;
    end else begin
      base6 = b[5:0]; mod6 = n[5:0]; exp6 = e[5:0]; start6 = 1'b1;
    end
    @(posedge clk);
    #1;
    start6 = 1'b0;
    start16 = 1'b0;
    lat = 0;
    seen = 1'b0;
    res = '0;
    er = 1'b0;
    while (lat < LIMIT && !seen) begin
      @(posedge clk);
      #1;
      lat++;
      start6 = 1'b0;
      if (lat == pulse_at) begin
        base6 = 6'd5; exp6 = 6'd1; start6 = 1'b1;
      end
      seen = (sel == 16) ? done16 : done6;
    end
    if (seen) begin
      res = (sel == 16) ? res16 : {10'd0, res6};
      er  = (sel == 16) ? err16 : err6;
    end
  endtask

  task automatic quietWindow(input int cycles, output int extra);
    extra = 0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (done6 || busy6 || done16 || busy16) extra++;
    end
  endtask

  initial begin
    logic [15:0] r;
    logic        er;
    int          lat;
    int          extra;

    #12;
    checkOutput("rst_result", res6, 0);
    checkOutput("rst_busy", busy6, 0);
    checkOutput("rst_done", done6, 0);
    checkOutput("rst_error", err6, 0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(6, 2, 33, 7, -1, r, er, lat);
    checkOutput("2^7_mod33", r, 29);
    checkOutput("2^7_err", er, 0);
    checkOutput("2^7_latency", lat, 74);

    applyStimulus(6, 29, 33, 3, -1, r, er, lat);
    checkOutput("29^3_mod33", r, 2);
    checkOutput("29^3_latency", lat, 74);

    applyStimulus(6, 7, 33, 0, -1, r, er, lat);
    checkOutput("exp0", r, 1);

    applyStimulus(6, 0, 1, 5, -1, r, er, lat);
    checkOutput("mod1", r, 0);
    checkOutput("mod1_err", er, 0);

    applyStimulus(6, 62, 63, 63, -1, r, er, lat);
    checkOutput("all_ones", r, 62);

    applyStimulus(6, 40, 33, 5, -1, r, er, lat);
    checkOutput("base_ge_mod_err", er, 1);
    checkOutput("base_ge_mod_res", r, 0);
    checkOutput("err_latency", lat, 2);

    applyStimulus(6, 5, 0, 3, -1, r, er, lat);
    checkOutput("mod0_err", er, 1);
    checkOutput("mod0_latency", lat, 2);

    applyStimulus(6, 2, 33, 7, 10, r, er, lat);
    checkOutput("busy_start_res", r, 29);
    checkOutput("busy_start_err_clr", er, 0);
    checkOutput("busy_start_latency", lat, 74);
    quietWindow(100, extra);
    checkOutput("busy_start_no_queue", extra, 0);

    @(negedge clk);
    base6 = 6'd29; mod6 = 6'd33; exp6 = 6'd3; start6 = 1'b1;
    @(posedge clk);
    #1;
    start6 = 1'b0;
    repeat (29) @(posedge clk);
    #2;
    checkOutput("abort_busy_before", busy6, 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_result", res6, 0);
    checkOutput("abort_busy", busy6, 0);
    checkOutput("abort_done", done6, 0);
    checkOutput("abort_error", err6, 0);
    @(negedge clk);
    rst = 1'b0;
    quietWindow(100, extra);
    checkOutput("abort_no_done", extra, 0);

    applyStimulus(6, 29, 33, 3, -1, r, er, lat);
    checkOutput("after_abort", r, 2);
    checkOutput("after_abort_latency", lat, 74);

    applyStimulus(16, 65, 3233, 17, -1, r, er, lat);
    checkOutput("rsa_encrypt", r, 2790);
    checkOutput("rsa_encrypt_latency", lat, 514);

    applyStimulus(16, 2790, 3233, 2753, -1, r, er, lat);
    checkOutput("rsa_decrypt", r, 65);
    checkOutput("rsa_decrypt_err", er, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
